// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU.
// Opcode names pair each logic op with its arithmetic twin.
package alu_pkg;

  typedef enum logic {
    MODE_LOGIC = 1'b0,
    MODE_ARITH = 1'b1
  } alu_mode_e;

  typedef enum logic [2:0] {
    OP_AND_ADD   = 3'b000,
    OP_OR_ADDC   = 3'b001,
    OP_XOR_SUB   = 3'b010,
    OP_NOR_SUBB  = 3'b011,
    OP_NOT_INC   = 3'b100,
    OP_PA_DEC    = 3'b101,
    OP_PB_SHL    = 3'b110,
    OP_NAND_SHR  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic s;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared adder
// serves every add/sub/inc/dec variant.
import alu_pkg::*;

module alu_core #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  input  logic              cin,
  output logic [DWIDTH-1:0] result,
  output alu_flags_t        flags
);

  localparam int M = DWIDTH - 1;

  logic [DWIDTH-1:0] b;
  logic              ci;
  logic [DWIDTH:0]   sum;
  logic              c;
  logic              v;

  always_comb begin
    b  = op2;
    ci = 1'b0;
    unique case (alu_op_e'(opsel))
      OP_OR_ADDC:  ci = cin;
      OP_XOR_SUB:  begin b = ~op2; ci = 1'b1; end
      OP_NOR_SUBB: begin b = ~op2; ci = cin;  end
      OP_NOT_INC:  begin b = '0;   ci = 1'b1; end
      OP_PA_DEC:   b = '1;
      default:     ;
    endcase
  end

  assign sum = {1'b0, op1} + {1'b0, b}
             + {{DWIDTH{1'b0}}, ci};

  always_comb begin
    result = '0;
    c      = cin;
    v      = 1'b0;
    if (alu_mode_e'(mode) == MODE_LOGIC) begin
      unique case (alu_op_e'(opsel))
        OP_AND_ADD:  result = op1 & op2;
        OP_OR_ADDC:  result = op1 | op2;
        OP_XOR_SUB:  result = op1 ^ op2;
        OP_NOR_SUBB: result = ~(op1 | op2);
        OP_NOT_INC:  result = ~op1;
        OP_PA_DEC:   result = op1;
        OP_PB_SHL:   result = op2;
        OP_NAND_SHR: result = ~(op1 & op2);
        default:     result = '0;
      endcase
    end else begin
      unique case (alu_op_e'(opsel))
        OP_PB_SHL: begin
          result = {op1[M-1:0], 1'b0};
          c      = op1[M];
          v      = op1[M] ^ op1[M-1];
        end
        OP_NAND_SHR: begin
          result = {1'b0, op1[M:1]};
          c      = op1[0];
        end
        default: begin
          result = sum[M:0];
          c      = sum[DWIDTH];
          v      = (op1[M] == b[M]) &&
                   (sum[M] != op1[M]);
        end
      endcase
    end
  end

  assign flags.c = c;
  assign flags.v = v;
  assign flags.z = (result == '0);
  assign flags.s = result[M];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU: S1 holds operands, S2 holds the
// computed result and flags; carry_q chains in order.
import alu_pkg::*;

module alu_pipe #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [2:0]        opsel,
  input  logic              mode,
  input  logic              c_load,
  input  logic              c_init,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              v_flag,
  output logic              z_flag,
  output logic              s_flag,
  output logic              carry_q
);

  logic              s1_valid;
  logic [DWIDTH-1:0] s1_op1;
  logic [DWIDTH-1:0] s1_op2;
  logic [2:0]        s1_opsel;
  logic              s1_mode;
  logic              s1_advance;
  logic [DWIDTH-1:0] core_result;
  alu_flags_t        core_flags;

  assign s1_advance = s1_valid &&
                      (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;

  alu_core #(.DWIDTH(DWIDTH)) u_core (
    .op1    (s1_op1),
    .op2    (s1_op2),
    .opsel  (s1_opsel),
    .mode   (s1_mode),
    .cin    (carry_q),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_opsel <= '0;
      s1_mode  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_op1   <= op1;
      s1_op2   <= op2;
      s1_opsel <= opsel;
      s1_mode  <= mode;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      c_flag    <= 1'b0;
      v_flag    <= 1'b0;
      z_flag    <= 1'b0;
      s_flag    <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= 1'b1;
      result    <= core_result;
      c_flag    <= core_flags.c;
      v_flag    <= core_flags.v;
      z_flag    <= core_flags.z;
      s_flag    <= core_flags.s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // An explicit load beats the advancing op's carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (c_load) begin
      carry_q <= c_init;
    end else if (s1_advance) begin
      carry_q <= core_flags.c;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases
// plus randomized traffic against an arithmetic model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  opsel;
  logic        mode;
  logic        c_load;
  logic        c_init;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        c_flag;
  logic        v_flag;
  logic        z_flag;
  logic        s_flag;
  logic        carry_q;

  int checks = 0;
  int failures = 0;
  logic [35:0] q[$];
  logic        mcarry;
  logic        acc;

  alu_pipe #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .opsel     (opsel),
    .mode      (mode),
    .c_load    (c_load),
    .c_init    (c_init),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_flag    (c_flag),
    .v_flag    (v_flag),
    .z_flag    (z_flag),
    .s_flag    (s_flag),
    .carry_q   (carry_q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Expected {result, c, v, z, s} from integer arithmetic.
  function automatic logic [35:0] model(
    logic [31:0] a, logic [31:0] b,
    logic [2:0] o, logic m, logic cin);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint u;
    longint sx;
    longint bor;
    logic [31:0] r;
    logic c;
    logic v;
    c = cin;
    v = 1'b0;
    r = '0;
    u = 0;
    sx = 0;
    if (!m) begin
      case (o)
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a ^ b;
        3'd3: r = ~(a | b);
        3'd4: r = ~a;
        3'd5: r = a;
        3'd6: r = b;
        default: r = ~(a & b);
      endcase
    end else begin
      case (o)
        3'd0, 3'd1, 3'd4: begin
          bor = (o == 3'd1) ? longint'(cin) : 0;
          if (o == 3'd4) begin
            u = ua + 1;
            sx = sa + 1;
          end else begin
            u = ua + ub + bor;
            sx = sa + sb + bor;
          end
          c = (u >= 64'sd4294967296);
          r = u[31:0];
        end
        3'd2, 3'd3, 3'd5: begin
          bor = (o == 3'd3) ? longint'(!cin) : 0;
          if (o == 3'd5) begin
            u = ua - 1;
            sx = sa - 1;
          end else begin
            u = ua - ub - bor;
            sx = sa - sb - bor;
          end
          c = (u >= 0);
          r = u[31:0];
        end
        3'd6: begin
          r = a << 1;
          c = a[31];
          v = a[31] ^ r[31];
        end
        default: begin
          r = a >> 1;
          c = a[0];
        end
      endcase
      if (o <= 3'd5)
        v = (sx > 64'sd2147483647) ||
            (sx < -64'sd2147483648);
    end
    return {r, c, v, (r == 32'd0), r[31]};
  endfunction

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set.
  task automatic cycle();
    logic [35:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0)
        chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("result_flags",
            {result, c_flag, v_flag, z_flag, s_flag}, e);
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e = model(op1, op2, opsel, mode, mcarry);
      mcarry = e[3];
      q.push_back(e);
    end
    if (c_load) mcarry = c_init;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b,
                       logic [2:0] o, logic m);
    op1 = a;
    op2 = b;
    opsel = o;
    mode = m;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk("issue_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op1 = '0;
    op2 = '0;
    opsel = '0;
    mode = 1'b0;
    c_load = 1'b0;
    c_init = 1'b0;
    out_ready = 1'b1;
    mcarry = 1'b0;
    acc = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_carry_q", 64'(carry_q), 64'd0);
    chk("rst_outputs",
        {result, c_flag, v_flag, z_flag, s_flag}, 64'd0);
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_carry_q", 64'(carry_q), 64'd0);

    c_load = 1'b1;
    c_init = 1'b1;
    cycle();
    c_load = 1'b0;
    chk("c_load_set", 64'(carry_q), 64'd1);
    c_load = 1'b1;
    c_init = 1'b0;
    cycle();
    c_load = 1'b0;
    chk("c_load_clr", 64'(carry_q), 64'd0);

    issue(32'hFFFF_FFFF, 32'h1, 3'd0, 1'b1);
    issue(32'h0, 32'h0, 3'd1, 1'b1);
    drain();
    chk("mp_carry_q", 64'(carry_q), 64'd0);

    issue(32'h0, 32'h1, 3'd2, 1'b1);
    issue(32'h5, 32'h2, 3'd3, 1'b1);
    issue(32'h8000_0000, 32'h1, 3'd2, 1'b1);
    issue(32'h0, 32'h0, 3'd5, 1'b1);
    issue(32'h7FFF_FFFF, 32'h0, 3'd4, 1'b1);
    issue(32'hC000_0001, 32'h0, 3'd6, 1'b1);
    issue(32'h0000_0003, 32'h0, 3'd7, 1'b1);
    drain();

    out_ready = 1'b0;
    issue(32'h10, 32'h20, 3'd0, 1'b1);
    issue(32'hF0F0, 32'h0FF0, 3'd2, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    op1 = 32'h3;
    op2 = 32'h4;
    opsel = 3'd3;
    mode = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      if (q.size() != 0)
        chk("bp_hold_data",
            {result, c_flag, v_flag, z_flag, s_flag},
            q[0]);
    end
    out_ready = 1'b1;
    issue(32'h3, 32'h4, 3'd3, 1'b0);
    issue(32'h7, 32'h9, 3'd1, 1'b1);
    drain();

    issue(32'h1, 32'h1, 3'd0, 1'b1);
    c_load = 1'b1;
    c_init = 1'b1;
    cycle();
    c_load = 1'b0;
    drain();
    chk("c_load_wins", 64'(carry_q), 64'd1);

    issue(32'h11, 32'h22, 3'd0, 1'b1);
    issue(32'h33, 32'h44, 3'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_carry_q", 64'(carry_q), 64'd0);
    q.delete();
    mcarry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle();
    chk("post_rst_quiet", 64'(out_valid), 64'd0);

    for (int i = 0; i < 200; i++) begin
      if (!in_valid || acc) begin
        ra = $urandom();
        rb = $urandom();
        if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) rb = 32'h8000_0000;
        op1 = ra;
        op2 = rb;
        opsel = 3'($urandom_range(0, 7));
        mode = 1'($urandom_range(0, 1));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_carry_q", 64'(carry_q), 64'(mcarry));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, 2-stage pipelined ALU. Successor to the 32-bit ripple ALU.
- Adds the following over its predecessor:
  - valid/ready handshakes on input and output.
  - An architectural carry register for multi-precision ADDC/SUBB chains.
  - Registered C/Z/S/V flags.
- Sits between the operand-fetch logic and result writeback in the datapath.

Parameters:
- DWIDTH, 32, operand and result width; legal range is 2 and up.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- op1  in  DWIDTH  operand A.
- op2  in  DWIDTH  operand B.
- opsel  in  3  operation select.
- mode  in  1  0 = logic group, 1 = arithmetic group.
- c_load  in  1  strobe: overwrite the architectural carry register.
- c_init  in  1  value written by c_load.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  DWIDTH  operation result.
- c_flag  out  1  carry of this result.
- v_flag  out  1  signed overflow of this result.
- z_flag  out  1  result == 0.
- s_flag  out  1  result[DWIDTH-1].
- carry_q  out  1  architectural carry register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - in_ready = 1; out_valid = 0.
  - result, c_flag, v_flag, z_flag, s_flag, carry_q = 0.
  - Both stage-valid bits = 0.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - The handshakes are independent; there are no combinational paths from in_valid to out_valid.
  - result and all flags hold stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers op1/op2/opsel/mode on an input transfer.
  - S1 advances to S2 when S2 is empty or S2 is transferring out. On that edge, alu_core computes from the S1 registers and carry_q.
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 op/cycle when out_ready is held high.
  - in_ready = !s1_valid || s1_advance. in_ready may depend combinationally on out_ready.
- Operations, mode=0 (logic group). C unchanged (c_flag = carry_q), V = 0:
  - 000 AND; 001 OR; 010 XOR; 011 NOR.
  - 100 NOT op1; 101 pass op1; 110 pass op2; 111 NAND.
- Operations, mode=1 (arithmetic group). All widths are DWIDTH; the carry-out is bit DWIDTH of a DWIDTH+1 sum:
  - 000 ADD op1+op2.
  - 001 ADDC op1+op2+carry_q.
  - 010 SUB op1+~op2+1.
  - 011 SUBB op1+~op2+carry_q.
  - 100 INC op1+1.
  - 101 DEC op1+all-ones.
  - 110 SHL1: C = op1[DWIDTH-1], lsb filled with 0.
  - 111 SHR1 logical: C = op1[0].
- Carry convention: C=1 means no borrow for SUB/SUBB/DEC.
- V flag:
  - Set for add/sub/inc/dec when the operand signs imply a result sign mismatch.
  - Equals op1[DWIDTH-1]^result[DWIDTH-1] for SHL1.
  - 0 for SHR1.
- carry_q update: on every S1-to-S2 advance, carry_q takes the new c_flag. Logic ops rewrite the unchanged value.
- Chaining:
  - Each op in S1 sees the carry_q of the immediately preceding op, because in-order advance guarantees this; no forwarding is needed.
  - Back-to-back ADDC at full rate is legal.
- c_load:
  - When c_load=1, carry_q takes c_init at the next edge.
  - If c_load coincides with an S1 advance, c_load wins for carry_q. The advancing op still computed with the old carry_q, and its own c_flag output is unaffected.
- Wrap-around: results truncate to DWIDTH. Examples: ADD all-ones+1 gives 0, C=1, Z=1. DEC 0 gives all-ones, C=0.
- Reset mid-operation: all in-flight ops are discarded and nothing is emitted after rst_n deasserts.

Decomposition:
- Package alu_pkg:
  - Typedef alu_mode_e {MODE_LOGIC, MODE_ARITH}.
  - Typedef alu_op_e, holding the 3-bit opsel encodings per group.
  - Typedef alu_flags_t struct {c, v, z, s}.
- Sub-module alu_core:
  - Purely combinational.
  - Inputs: op1, op2, opsel, mode, cin.
  - Outputs: result and alu_flags_t.
  - alu_pipe instantiates one alu_core plus the pipeline and carry registers.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n low, then high; in_valid=0.
   - Required: out_valid=0, carry_q=0, in_ready=1.
2. Multi-precision add, DWIDTH=32:
   - Stimulus: c_load with c_init=0. Then ADD 0xFFFFFFFF+0x00000001, back-to-back with ADDC 0x00000000+0x00000000.
   - Required: first result 0x0 with C=1, Z=1. Second result 0x1 with C=0.
3. SUB/SUBB borrow and overflow:
   - SUB 0x0-0x1 -> 0xFFFFFFFF, C=0, S=1.
   - Following SUBB 0x5-0x2 -> 0x2 (borrow applied).
   - SUB 0x80000000-1 -> 0x7FFFFFFF, V=1.
4. Backpressure:
   - Stimulus: 4 ops issued, out_ready=0 for 5 cycles.
   - Required: in_ready=0 after 2 ops accepted; outputs hold stable; on release, results emerge in order with no loss or duplication.
5. c_load collision:
   - Stimulus: c_load=1, c_init=1 in the same cycle an ADD 1+1 advances to S2.
   - Required: result 2, c_flag=0, carry_q=1 afterwards.
6. Reset mid-stream:
   - Stimulus: rst_n asserted while 2 ops are in flight.
   - Required: out_valid=0 immediately; no stale result emitted after rst_n deasserts.
